// File: rtl/uart_tx_drain.sv
// UART transmit back-end: pops bytes from a fall-through FIFO and shifts them
// out as 8N1/8N2 frames, chaining frames back-to-back while data is waiting.
module uart_tx_drain #(
    parameter int CLK_DIV   = 542,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_deq,
    input  logic       cts,
    output logic       tx,
    output logic       busy
);

    localparam int BC_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state, w_state_n;
    logic [7:0]        r_sh, w_sh_n;
    logic [2:0]        r_bitn, w_bitn_n;
    logic [BC_W-1:0]   r_bc, w_bc_n;
    logic              r_stop, w_stop_n;
    logic              r_tx, w_tx_n;
    logic              r_busy, w_busy_n;
    logic              w_go;
    logic              w_bit_end;
    logic              w_pop;

    assign w_go      = !fifo_empty && cts;
    assign w_bit_end = (r_bc == BC_W'(CLK_DIV - 1));

    always_comb begin
        w_state_n = r_state;
        w_sh_n    = r_sh;
        w_bitn_n  = r_bitn;
        w_bc_n    = r_bc + 1'b1;
        w_stop_n  = r_stop;
        w_tx_n    = r_tx;
        w_busy_n  = r_busy;
        w_pop     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_bc_n   = '0;
                w_stop_n = 1'b0;
                w_pop    = w_go;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bc_n    = '0;
                    w_tx_n    = r_sh[0];
                    w_bitn_n  = 3'd0;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bc_n   = '0;
                    w_sh_n   = r_sh >> 1;
                    w_bitn_n = r_bitn + 3'd1;
                    if (r_bitn == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_stop_n  = 1'b0;
                        w_state_n = S_STOP;
                    end else begin
                        w_tx_n = r_sh[1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_bc_n = '0;
                    if (r_stop == 1'(STOP_BITS - 1)) begin
                        // Last stop cycle doubles as a launch slot for the next byte.
                        w_pop = w_go;
                        if (!w_go) begin
                            w_state_n = S_IDLE;
                            w_busy_n  = 1'b0;
                            w_stop_n  = 1'b0;
                        end
                    end else begin
                        w_stop_n = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
                w_tx_n    = 1'b1;
            end
        endcase

        if (w_pop) begin
            w_state_n = S_START;
            w_sh_n    = fifo_dout;
            w_bc_n    = '0;
            w_stop_n  = 1'b0;
            w_tx_n    = 1'b0;
            w_busy_n  = 1'b1;
        end
    end

    // Registers sit at reset while rst is low, so the strobe is gated to keep it quiet too.
    assign fifo_deq = w_pop && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_bitn  <= '0;
            r_bc    <= '0;
            r_stop  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sh    <= w_sh_n;
            r_bitn  <= w_bitn_n;
            r_bc    <= w_bc_n;
            r_stop  <= w_stop_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: table of single frames plus hand-written
// sequences for reset, back-to-back, flow control, two stop bits and mid-frame reset.
module tb_uart_tx_drain;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       cts1, cts2;
    logic       fifo_empty1, fifo_empty2;
    logic [7:0] fifo_dout1, fifo_dout2;
    logic       fifo_deq1, fifo_deq2;
    logic       tx1, tx2, busy1, busy2;

    logic [7:0] mem1 [0:63];
    logic [7:0] mem2 [0:63];
    int         wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
    logic       pend1 = 1'b0, pend2 = 1'b0;
    int         cyc = 0;
    int         deq_cnt1 = 0, deq_cnt2 = 0;
    int         t_last1 = 0, t_prev1 = 0, t_last2 = 0, t_prev2 = 0;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_drain #(.CLK_DIV(DIV), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_dout(fifo_dout1),
        .fifo_deq(fifo_deq1), .cts(cts1), .tx(tx1), .busy(busy1)
    );

    uart_tx_drain #(.CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
        .fifo_deq(fifo_deq2), .cts(cts2), .tx(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fall-through FIFO models; pops are applied on the falling edge after a deq edge.
    assign fifo_empty1 = (wr1 == rd1);
    assign fifo_dout1  = mem1[rd1[5:0]];
    assign fifo_empty2 = (wr2 == rd2);
    assign fifo_dout2  = mem2[rd2[5:0]];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pend1 <= fifo_deq1;
        pend2 <= fifo_deq2;
        if (fifo_deq1) begin
            deq_cnt1 <= deq_cnt1 + 1;
            t_prev1  <= t_last1;
            t_last1  <= cyc;
        end
        if (fifo_deq2) begin
            deq_cnt2 <= deq_cnt2 + 1;
            t_prev2  <= t_last2;
            t_last2  <= cyc;
        end
    end

    always @(negedge clk) begin
        if (pend1) rd1 <= rd1 + 1;
        if (pend2) rd2 <= rd2 + 1;
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;
    } vec_t;

    vec_t tab [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1[5:0]] = b;
        wr1 = wr1 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2[5:0]] = b;
        wr2 = wr2 + 1;
    endtask

    function automatic logic [127:0] expand(input logic [31:0] bits, input int nb);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < DIV; j++)
                w[i*DIV + j] = bits[i];
        return w;
    endfunction

    // Waits (bounded) for a pop strobe, then records tx/busy for n cycles from the pop edge.
    task automatic capture(input bit which, input int n,
                           output logic [127:0] txw, output logic [127:0] bw);
        int t;
        t   = 0;
        txw = '0;
        bw  = '0;
        while (((which ? fifo_deq2 : fifo_deq1) !== 1'b1) && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("deq_seen", which ? fifo_deq2 : fifo_deq1, 1);
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            txw[k] = which ? tx2 : tx1;
            bw[k]  = which ? busy2 : busy1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] txw, bw;
        int           d0;
        bit           ok;

        tab[0] = '{8'hA5, 10'b1101001010};
        tab[1] = '{8'h00, 10'b1000000000};
        tab[2] = '{8'hFF, 10'b1111111110};
        tab[3] = '{8'h3C, 10'b1001111000};
        tab[4] = '{8'h01, 10'b1000000010};
        tab[5] = '{8'h80, 10'b1100000000};

        rst  = 1'b0;
        cts1 = 1'b1;
        cts2 = 1'b1;

        // Reset held with data waiting: outputs quiet, pop right after release.
        push1(8'h11);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_tx", tx1, 1);
            chk("rst_busy", busy1, 0);
            chk("rst_deq", fifo_deq1, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_deq", fifo_deq1, 1);
        capture(0, 44, txw, bw);
        chk("release_frame_tx", txw, expand(32'h622, 11));
        chk("release_frame_busy", bw, expand(32'h3FF, 11));

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d0 = deq_cnt1;
            push1(tab[i].din);
            #1;
            capture(0, 44, txw, bw);
            chk($sformatf("frame_%02h_tx", tab[i].din), txw, expand({21'd0, 1'b1, tab[i].frame}, 11));
            chk($sformatf("frame_%02h_busy", tab[i].din), bw, expand(32'h3FF, 11));
            chk($sformatf("frame_%02h_deqs", tab[i].din), deq_cnt1 - d0, 1);
        end

        // Back-to-back 0x00, 0xFF.
        @(negedge clk);
        d0 = deq_cnt1;
        push1(8'h00);
        push1(8'hFF);
        #1;
        capture(0, 84, txw, bw);
        chk("b2b_tx", txw, expand(32'h1FFA00, 21));
        chk("b2b_busy", bw, expand(32'h0FFFFF, 21));
        chk("b2b_deqs", deq_cnt1 - d0, 2);
        chk("b2b_gap", t_last1 - t_prev1, 40);

        // Flow control.
        @(negedge clk);
        cts1 = 1'b0;
        d0 = deq_cnt1;
        push1(8'h5A);
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (tx1 !== 1'b1 || fifo_deq1 !== 1'b0) ok = 1'b0;
        end
        chk("cts_hold_idle", ok, 1);
        chk("cts_no_pop", deq_cnt1 - d0, 0);
        @(negedge clk);
        cts1 = 1'b1;
        #1;
        chk("cts_pop_same_cycle", fifo_deq1, 1);
        fork
            capture(0, 44, txw, bw);
            begin
                repeat (10) @(negedge clk);
                cts1 = 1'b0;
            end
        join
        chk("cts_drop_frame_tx", txw, expand(32'h6B4, 11));
        chk("cts_drop_frame_busy", bw, expand(32'h3FF, 11));
        cts1 = 1'b1;

        // Two stop bits, 0x55 twice.
        @(negedge clk);
        push2(8'h55);
        push2(8'h55);
        #1;
        capture(1, 92, txw, bw);
        chk("stop2_tx", txw, expand(32'h7556AA, 23));
        chk("stop2_busy", bw, expand(32'h3FFFFF, 23));
        chk("stop2_gap", t_last2 - t_prev2, 44);

        // Asynchronous reset in bit 3 of 0x3C, then 0xC3 queued.
        @(negedge clk);
        push1(8'h3C);
        #1;
        capture(0, 17, txw, bw);
        chk("mid_busy_before", bw[16], 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", tx1, 1);
        chk("mid_rst_busy", busy1, 0);
        @(negedge clk);
        push1(8'hC3);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("mid_rst_deq_low", fifo_deq1, 0);
        end
        @(negedge clk);
        d0 = deq_cnt1;
        rst = 1'b1;
        #1;
        chk("mid_release_deq", fifo_deq1, 1);
        capture(0, 44, txw, bw);
        chk("mid_next_tx", txw, expand(32'h786, 11));
        chk("mid_next_busy", bw, expand(32'h3FF, 11));
        repeat (20) @(negedge clk);
        chk("mid_no_resend", deq_cnt1 - d0, 1);
        chk("mid_fifo_empty", fifo_empty1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmit back-end that drains the byte FIFO (`myfifo`, WIDTH=8) and shifts each byte out as an 8N1/8N2 UART frame. It sits directly downstream of the TX FIFO: it watches the FIFO's `empty`, samples its fall-through `dout`, and issues single-cycle `deq` pops. Back-to-back frames run with no idle gap while data is available.

## Interface
- `CLK_DIV`, 542: clock cycles per bit (62.5 MHz / 115200). Must be ≥ 2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserting `rst`=0 resets all state immediately.
- `fifo_empty` input 1: FIFO `empty`.
- `fifo_dout` input 8: FIFO `dout`. Fall-through; valid whenever `fifo_empty`=0.
- `fifo_deq` output 1: pop strobe to FIFO `deq`. Combinational; high for exactly one cycle per frame.
- `cts` input 1: clear-to-send, active-high. Tie to 1 if unused.
- `tx` output 1: serial line, registered. Idles high.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE), registered.

## Operation
- States: IDLE, START, DATA, STOP.
- Internal registers:
  - 8-bit shift register `sh`.
  - Bit counter `bitn` (0..7).
  - Baud counter `bc`, width `$clog2(CLK_DIV)`. Counts 0..CLK_DIV-1.
  - Stop counter (0..STOP_BITS-1).
- Launch condition `go` = `fifo_empty`=0 and `cts`=1. It is evaluated only in IDLE, and in the last cycle of STOP.
- `fifo_deq` = `go` in those cycles. It is 0 in every other cycle and 0 while `rst`=0.
- On a pop edge:
  - `sh` ← `fifo_dout`; state ← START; `bc` ← 0; `tx` ← 0; `busy` ← 1.
- START: hold `tx`=0 for CLK_DIV cycles. Then `tx` ← `sh[0]`, `bitn` ← 0, state ← DATA.
- DATA: each bit is held for CLK_DIV cycles, LSB first. At each bit end:
  - `sh` shifts right and `bitn` increments.
  - After bit 7 completes, `tx` ← 1 and state ← STOP.
- STOP: `tx`=1 for STOP_BITS×CLK_DIV cycles. In the final cycle:
  - If `go`, pop and go to START (no idle gap).
  - Otherwise state ← IDLE and `busy` ← 0.
- `cts` is sampled only at launch. Deasserting it mid-frame never aborts or truncates the frame.
- `fifo_dout` is ignored whenever no pop occurs. A changing `dout` mid-frame has no effect because data is latched at pop.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_deq`=0, state=IDLE, all counters 0.
- Launch latency: in IDLE with FIFO non-empty and `cts`=1, `fifo_deq` is high in that same cycle. Call the next rising edge the pop edge E; `tx` falls at E.
- Frame layout relative to E:
  - Start bit occupies [E, E+CLK_DIV).
  - Data bit i occupies [E+(1+i)·CLK_DIV, E+(2+i)·CLK_DIV).
  - Stop begins at E+9·CLK_DIV.
- Frame period is exactly (9+STOP_BITS)·CLK_DIV cycles.
- Next pop edge:
  - Earliest at E+(9+STOP_BITS)·CLK_DIV.
  - If FIFO is empty at that point, the launch occurs one cycle after data appears in IDLE.
- FIFO simultaneity: an upstream `enq` in the same cycle as `fifo_deq` is legal. This block relies on `myfifo` accepting both.
- Empty boundary: `fifo_deq` is never asserted when `fifo_empty`=1.
- Reset mid-frame:
  - `tx` goes to 1 and `busy` goes to 0 asynchronously.
  - The popped byte is discarded and not re-fetched.
  - After release, operation restarts from IDLE on the first clock edge.
- `busy` rises at E and falls at the end of STOP only when no back-to-back launch occurs. It stays high continuously across back-to-back frames.

## Test plan
All scenarios use CLK_DIV=4 and STOP_BITS=1 unless stated.
- Reset: hold `rst`=0 with FIFO non-empty, then release. Required: `tx`=1, `busy`=0, `fifo_deq`=0 throughout reset; first pop occurs in the first cycle after release.
- Single byte 0xA5: push 0xA5 into an idle empty FIFO. Required:
  - One `fifo_deq` pulse.
  - `tx` sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 40 cycles, then IDLE.
- Back-to-back 0x00 then 0xFF preloaded. Required:
  - Two `deq` pulses exactly 40 cycles apart.
  - `tx` sequence: 0 for 36 cycles, 1 for 4, 0 for 4, 1 for 36.
  - `busy` never drops between frames.
- Flow control:
  - With `cts`=0 and FIFO non-empty, no pop occurs for 100 cycles and `tx`=1.
  - Raise `cts` and the pop follows the same cycle.
  - Drop `cts` mid-frame: the frame completes with 10 bits intact.
- STOP_BITS=2, byte 0x55 twice. Required: frame period 44 cycles, with `tx`=1 for 8 cycles between the last data bit and the next start bit.
- Async reset mid-DATA: assert `rst`=0 at bit 3 of 0x3C, off a clock edge. Required:
  - `tx`=1 and `busy`=0 immediately, before the next edge.
  - After release, the next queued byte transmits correctly and 0x3C is not resent.
